// File: rtl/divider_pkg.sv
// Shared definitions for the iterative divider: operation codes, FSM states
// and iteration bookkeeping.
package divider_pkg;

    typedef enum logic [1:0] {
        FN_DIV  = 2'd0,
        FN_DIVU = 2'd1,
        FN_REM  = 2'd2,
        FN_REMU = 2'd3
    } fn_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int ITERS = 32;
    localparam int CNT_W = 6;

    function automatic logic fn_is_signed(input fn_e f);
        return (f == FN_DIV) || (f == FN_REM);
    endfunction

    function automatic logic fn_is_rem(input fn_e f);
        return (f == FN_REM) || (f == FN_REMU);
    endfunction

endpackage

// File: rtl/divider_adder.sv
// Generic adder/subtractor; addsub=1 computes a - b via two's complement.
module divider_adder #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             addsub,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff = addsub ? ~b : b;
    assign sum   = a + b_eff + WIDTH'(addsub);

endmodule

// File: rtl/divider.sv
// Fixed-latency restoring divider: one quotient bit per CALC cycle, plus one
// final CALC cycle that applies signs and registers the result.
module divider
    import divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      fn,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] out,
    output logic            zero
);

    state_e           state_q, state_d;
    logic             accept, finish;
    fn_e              fn_in, fn_q;
    logic             in_signed, x_neg, y_neg;
    logic [XLEN-1:0]  x_mag, y_mag;
    logic [XLEN-1:0]  rem_q, quo_q, div_q;
    logic [CNT_W-1:0] count_q;
    logic             q_neg_q, r_neg_q;
    logic [XLEN:0]    shifted, diff;
    logic             borrow;
    logic [XLEN-1:0]  q_res, r_res, result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        busy    = 1'b0;
        valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    accept  = 1'b1;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count_q == CNT_W'(ITERS)) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                valid   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are reduced to magnitudes at capture; signs are reapplied at the end.
    always_comb begin
        fn_in     = fn_e'(fn);
        in_signed = fn_is_signed(fn_in);
        x_neg     = in_signed && x[XLEN-1];
        y_neg     = in_signed && y[XLEN-1];
        x_mag     = x_neg ? -x : x;
        y_mag     = y_neg ? -y : y;
    end

    assign shifted = {rem_q, quo_q[XLEN-1]};

    divider_adder #(
        .WIDTH(XLEN + 1)
    ) u_trial_sub (
        .a     (shifted),
        .b     ({1'b0, div_q}),
        .addsub(1'b1),
        .sum   (diff)
    );

    // Partial remainder stays below the divisor, so the top difference bit is the borrow.
    assign borrow = diff[XLEN];

    always_comb begin
        q_res  = q_neg_q ? -quo_q : quo_q;
        r_res  = r_neg_q ? -rem_q : rem_q;
        result = fn_is_rem(fn_q) ? r_res : q_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            count_q <= '0;
            fn_q    <= FN_DIV;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            out     <= '0;
            zero    <= 1'b1;
        end else if (accept) begin
            rem_q   <= '0;
            quo_q   <= x_mag;
            div_q   <= y_mag;
            count_q <= '0;
            fn_q    <= fn_in;
            // A zero divisor must yield an all-ones quotient, so never negate it.
            q_neg_q <= (x_neg ^ y_neg) && (y != '0);
            r_neg_q <= x_neg;
        end else if (busy) begin
            if (finish) begin
                out  <= result;
                zero <= (result == '0);
            end else begin
                rem_q   <= borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                quo_q   <= {quo_q[XLEN-2:0], ~borrow};
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider: latency, signed/unsigned
// results, divide-by-zero, overflow, ignored starts and reset abort.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  fn;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        valid;
    logic [31:0] out;
    logic        zero;

    int checks = 0;
    int errors = 0;

    divider #(.XLEN(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .fn   (fn),
        .x    (x),
        .y    (y),
        .busy (busy),
        .valid(valid),
        .out  (out),
        .zero (zero)
    );

    always #5 clk = ~clk;

    // Issues one operation and watches 40 cycles after acceptance.
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int pulses, output int overlap,
                          output logic busy_at_accept);
        @(negedge clk);
        fn = f; x = a; y = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_at_accept = busy;
        lat = -1; pulses = 0; overlap = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                pulses++;
                if (lat < 0) lat = i;
            end
            if (busy && valid) overlap++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; fn = 2'd0; x = '0; y = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (out !== 32'h0)   begin errors++; $display("[TB] FAIL reset_out: got %h expected 00000000", out); end
        checks++; if (zero !== 1'b1)   begin errors++; $display("[TB] FAIL reset_zero: got %b expected 1", zero); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, pulses, overlap; logic ba;
        run_op(2'd0, 32'd100, 32'd7, lat, pulses, overlap, ba);
        checks++; if (ba !== 1'b1)      begin errors++; $display("[TB] FAIL basic_busy: got %b expected 1", ba); end
        checks++; if (lat != 33)        begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 33", lat); end
        checks++; if (pulses != 1)      begin errors++; $display("[TB] FAIL basic_pulses: got %0d expected 1", pulses); end
        checks++; if (overlap != 0)     begin errors++; $display("[TB] FAIL basic_overlap: got %0d expected 0", overlap); end
        checks++; if (out !== 32'd14)   begin errors++; $display("[TB] FAIL basic_out: got %h expected 0000000e", out); end
        checks++; if (zero !== 1'b0)    begin errors++; $display("[TB] FAIL basic_zero: got %b expected 0", zero); end
    endtask

    task automatic test_signed();
        int lat, pulses, overlap; logic ba;
        run_op(2'd0, 32'hFFFF_FFF9, 32'd2, lat, pulses, overlap, ba);
        checks++; if (out !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL signed_div: got %h expected fffffffd", out); end
        checks++; if (lat != 33)             begin errors++; $display("[TB] FAIL signed_latency: got %0d expected 33", lat); end
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, lat, pulses, overlap, ba);
        checks++; if (out !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL signed_rem: got %h expected ffffffff", out); end
        run_op(2'd1, 32'hFFFF_FFF9, 32'd2, lat, pulses, overlap, ba);
        checks++; if (out !== 32'h7FFF_FFFC) begin errors++; $display("[TB] FAIL unsigned_div: got %h expected 7ffffffc", out); end
    endtask

    task automatic test_div_zero();
        int lat, pulses, overlap; logic ba;
        run_op(2'd1, 32'h1234_5678, 32'd0, lat, pulses, overlap, ba);
        checks++; if (out !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL divu_zero: got %h expected ffffffff", out); end
        checks++; if (lat != 33)             begin errors++; $display("[TB] FAIL divzero_latency: got %0d expected 33", lat); end
        run_op(2'd3, 32'h1234_5678, 32'd0, lat, pulses, overlap, ba);
        checks++; if (out !== 32'h1234_5678) begin errors++; $display("[TB] FAIL remu_zero: got %h expected 12345678", out); end
        run_op(2'd0, 32'hFFFF_FFF9, 32'd0, lat, pulses, overlap, ba);
        checks++; if (out !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_zero_neg: got %h expected ffffffff", out); end
        run_op(2'd2, 32'hFFFF_FFF9, 32'd0, lat, pulses, overlap, ba);
        checks++; if (out !== 32'hFFFF_FFF9) begin errors++; $display("[TB] FAIL rem_zero_neg: got %h expected fffffff9", out); end
    endtask

    task automatic test_overflow();
        int lat, pulses, overlap; logic ba;
        run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, lat, pulses, overlap, ba);
        checks++; if (out !== 32'h8000_0000) begin errors++; $display("[TB] FAIL ovf_div: got %h expected 80000000", out); end
        checks++; if (zero !== 1'b0)         begin errors++; $display("[TB] FAIL ovf_div_zero: got %b expected 0", zero); end
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, pulses, overlap, ba);
        checks++; if (out !== 32'h0)         begin errors++; $display("[TB] FAIL ovf_rem: got %h expected 00000000", out); end
        checks++; if (zero !== 1'b1)         begin errors++; $display("[TB] FAIL ovf_rem_zero: got %b expected 1", zero); end
    endtask

    task automatic test_ignored_start();
        int lat, pulses;
        @(negedge clk);
        fn = 2'd3; x = 32'd10; y = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1; pulses = 0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                pulses++;
                if (lat < 0) lat = i;
            end
            if (i == 5) begin
                x = 32'd99; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (lat != 33)     begin errors++; $display("[TB] FAIL ignore_latency: got %0d expected 33", lat); end
        checks++; if (pulses != 1)   begin errors++; $display("[TB] FAIL ignore_pulses: got %0d expected 1", pulses); end
        checks++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL ignore_out: got %h expected 00000000", out); end
        checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL ignore_zero: got %b expected 1", zero); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic seen;
        @(negedge clk);
        fn = 2'd1; x = 32'd50; y = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = valid;
        end
        checks++; if (!seen)          begin errors++; $display("[TB] FAIL b2b_first_valid: got none expected pulse"); end
        checks++; if (out !== 32'd10) begin errors++; $display("[TB] FAIL b2b_first_out: got %h expected 0000000a", out); end
        fn = 2'd0; x = 32'hFFFF_FFEC; y = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL b2b_done_start: busy got %b expected 0", busy); end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1)  begin errors++; $display("[TB] FAIL b2b_idle_start: busy got %b expected 1", busy); end
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (valid) lat = i;
        end
        checks++; if (lat != 33)             begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 33", lat); end
        checks++; if (out !== 32'hFFFF_FFFA) begin errors++; $display("[TB] FAIL b2b_second_out: got %h expected fffffffa", out); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_abort();
        int lat, pulses, overlap; logic ba;
        @(negedge clk);
        fn = 2'd0; x = 32'd1000; y = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL abort_out: got %h expected 00000000", out); end
        checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL abort_zero: got %b expected 1", zero); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
        end
        checks++; if (pulses != 0)   begin errors++; $display("[TB] FAIL abort_no_valid: got %0d pulses expected 0", pulses); end
        checks++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL abort_out_held: got %h expected 00000000", out); end
        run_op(2'd1, 32'd9, 32'd3, lat, pulses, overlap, ba);
        checks++; if (out !== 32'd3) begin errors++; $display("[TB] FAIL restart_out: got %h expected 00000003", out); end
        checks++; if (lat != 33)     begin errors++; $display("[TB] FAIL restart_latency: got %0d expected 33", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be asynchronous and active-high.
REQ-002 Parameter: XLEN, default 32, operand/result width; only 32 SHALL be required to work.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request strobe; sampled only while busy=0.
REQ-006 fn  input  2  operation: 0 DIV (signed quotient), 1 DIVU, 2 REM (signed remainder), 3 REMU.
REQ-007 x  input  32  dividend; sampled with start.
REQ-008 y  input  32  divisor; sampled with start.
REQ-009 busy  output  1  high from the cycle after an accepted start until valid is asserted.
REQ-010 valid  output  1  one-cycle result strobe.
REQ-011 out  output  32  result; held stable from valid until the next valid.
REQ-012 zero  output  1  out==0; registered alongside out.

Function
REQ-013 States: IDLE, CALC, DONE; IDLE->CALC on start; CALC->DONE after exactly 32 iterations; DONE->IDLE unconditionally after one cycle.
REQ-014 A start seen at clock edge N SHALL yield valid=1 during the cycle after edge N+33; latency is fixed at 33 cycles for all operands and all fn values, including special cases.
REQ-015 start, x, y, fn SHALL be captured into internal registers at acceptance; input changes during CALC SHALL have no effect.
REQ-016 start while busy=1 or in DONE SHALL be ignored, with no queuing.
REQ-017 Core: restoring division on magnitudes, one quotient bit per CALC cycle, MSB first; 33-bit partial remainder, with trial subtraction of the divisor each cycle.
REQ-018 Signed ops (fn 0, 2): magnitudes are taken at capture; quotient is negated when the signs of x and y differ; remainder takes the sign of x.
REQ-019 Divide by zero (y=0): the quotient SHALL be 0xFFFFFFFF for both DIV and DIVU; the remainder SHALL be x for both REM and REMU.
REQ-020 Signed overflow (x=0x80000000, y=0xFFFFFFFF, fn 0/2): quotient 0x80000000, remainder 0.
REQ-021 out and zero SHALL update only on the edge that enters DONE; valid SHALL be high only in DONE.
REQ-022 busy SHALL be high exactly in CALC; busy and valid SHALL never be high together.
REQ-023 A start in the cycle that valid is high SHALL be ignored; the earliest accepted restart is in the following IDLE cycle.

Reset
REQ-024 On rst: state IDLE, busy=0, valid=0, out=0, zero=1; internal remainder, quotient, and counter SHALL be cleared.
REQ-025 Reset during CALC or DONE SHALL abort the operation with no valid pulse; no partial result SHALL reach out.
REQ-026 The first start after reset deassertion SHALL be accepted normally.

Structure
REQ-027 The shared package SHALL hold the fn encodings (DIV, DIVU, REM, REMU), the state encoding, and the iteration count constant (32).
REQ-028 The trial subtraction SHALL instantiate the codebase adder in subtract mode (addsub=1) as the only sub-module; the remaining logic SHALL be inline.
REQ-029 The iteration counter SHALL be 6 bits wide, saturating at 32, with no wrap.

Verification
REQ-030 Test: fn=0, x=100, y=7 -> out=14, zero=0, valid exactly 33 cycles after start.
REQ-031 Test: fn=0 x=0xFFFFFFF9 (-7), y=2 -> out=0xFFFFFFFD. Test: fn=2 with the same operands -> out=0xFFFFFFFF.
REQ-032 Test: fn=1 x=0x12345678, y=0 -> out=0xFFFFFFFF. Test: fn=3 with the same operands -> out=0x12345678.
REQ-033 Test: fn=0 x=0x80000000, y=0xFFFFFFFF -> out=0x80000000. Test: fn=2 with the same operands -> out=0, zero=1.
REQ-034 Test: start fn=3 x=10 y=5, then a second start 5 cycles later with x=99 -> the second start is ignored, out=0, zero=1, one valid pulse only.
REQ-035 Test: assert rst at cycle 20 of CALC -> busy=0, out=0, no valid; a following start of fn=1 x=9 y=3 -> out=3 after 33 cycles.
